pwm_hbridge_mc: RTL and testbench

- Parametrised successor to the single-channel PWM unit that drives the DC motor H-bridge. Generates NUM_CH independent sign-magnitude PWM pairs (CH_A/CH_B) from two's-complement duty words written off the ALU result bus.
- Duty updates are double-buffered to the period boundary, and a programmable dead time is inserted on every direction reversal.
- Sits beside the digital core. wrt_duty/dst come from the core exactly as for the existing PWM; wrt_ch selects the channel.

---
 rtl/pwm_hbridge_mc.sv | 197 +++++++++++++++++++
 tb/tb_pwm_hbridge_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_hbridge_mc.sv
// Multi-channel sign-magnitude H-bridge PWM with period-aligned duty updates and reversal dead time.
// Optional short-brake input enabled by defining PWM_BRAKE_EN.
module pwm_hbridge_mc #(
    parameter int unsigned NUM_CH   = 1,
    parameter int unsigned DUTY_W   = 14,
    parameter int unsigned DEAD_CYC = 16
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [DUTY_W-1:0]                                duty,
    input  logic                                             wrt_duty,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   wrt_ch,
    output logic [NUM_CH-1:0]                                CH_A,
    output logic [NUM_CH-1:0]                                CH_B,
    output logic                                             period_strt
`ifdef PWM_BRAKE_EN
    ,
    input  logic                                             brake
`endif
);

    localparam int unsigned       CNT_W    = DUTY_W - 1;
    localparam int unsigned       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  DEAD_L   = CNT_W'(DEAD_CYC);
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              period_strt_q, period_strt_d;
    logic [DUTY_W-1:0] pend_q [NUM_CH];
    logic [DUTY_W-1:0] pend_d [NUM_CH];
    logic [DUTY_W-1:0] act_q  [NUM_CH];
    logic [DUTY_W-1:0] act_d  [NUM_CH];
    logic [CNT_W-1:0]  dead_q [NUM_CH];
    logic [CNT_W-1:0]  dead_d [NUM_CH];
    logic [NUM_CH-1:0] pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0] dir_q, dir_d;
    logic [NUM_CH-1:0] ch_a_q, ch_a_d;
    logic [NUM_CH-1:0] ch_b_q, ch_b_d;
    logic              cnt_max_s;
    logic              wr_en_s;
`ifdef PWM_BRAKE_EN
    logic              brake_hold_q, brake_hold_d;
    logic              brake_rel_s;
`endif

    // |d| clipped to the counter range so the most negative word still fits
    function automatic logic [CNT_W-1:0] mag_of(input logic [DUTY_W-1:0] d);
        logic [DUTY_W-1:0] abs_v;
        if (d[DUTY_W-1]) begin
            abs_v = ~d + DUTY_W'(1);
        end else begin
            abs_v = d;
        end
        if (abs_v[DUTY_W-1]) begin
            return CNT_MAX;
        end else begin
            return abs_v[CNT_W-1:0];
        end
    endfunction

    // Next-state: counter, buffered duty update, dead time and PWM compare
    always_comb begin
        logic             hit_v;
        logic             upd_v;
        logic             rev_v;
        logic             ld_v;
        logic             run_v;
        logic             new_sign_v;
        logic [CNT_W-1:0] new_mag_v;
        logic [CNT_W-1:0] mag_v;

        cnt_max_s     = (cnt_q == CNT_MAX);
        cnt_d         = cnt_q + CNT_W'(1);
        period_strt_d = cnt_max_s;
        wr_en_s       = wrt_duty & ({1'b0, wrt_ch} < NUM_CH_L);
        pend_vld_d    = pend_vld_q;
        dir_d         = dir_q;
        ch_a_d        = '0;
        ch_b_d        = '0;
`ifdef PWM_BRAKE_EN
        brake_rel_s   = brake_hold_q & ~brake & cnt_max_s;
        if (brake) begin
            brake_hold_d = 1'b1;
        end else if (cnt_max_s) begin
            brake_hold_d = 1'b0;
        end else begin
            brake_hold_d = brake_hold_q;
        end
`endif

        for (int i = 0; i < NUM_CH; i++) begin
            hit_v = wr_en_s & (wrt_ch == CH_W'(i));

            // A write landing on the boundary cycle bypasses the pending slot
            if (cnt_max_s && hit_v) begin
                act_d[i]      = duty;
                pend_d[i]     = duty;
                pend_vld_d[i] = 1'b0;
                upd_v         = 1'b1;
            end else if (cnt_max_s && pend_vld_q[i]) begin
                act_d[i]      = pend_q[i];
                pend_d[i]     = pend_q[i];
                pend_vld_d[i] = 1'b0;
                upd_v         = 1'b1;
            end else if (hit_v) begin
                act_d[i]      = act_q[i];
                pend_d[i]     = duty;
                pend_vld_d[i] = 1'b1;
                upd_v         = 1'b0;
            end else begin
                act_d[i]      = act_q[i];
                pend_d[i]     = pend_q[i];
                upd_v         = 1'b0;
            end

            new_sign_v = act_d[i][DUTY_W-1];
            new_mag_v  = mag_of(act_d[i]);
            rev_v      = upd_v & (new_mag_v != '0) & (new_sign_v != dir_q[i]);
            if (rev_v) begin
                dir_d[i] = new_sign_v;
            end else begin
                dir_d[i] = dir_q[i];
            end
`ifdef PWM_BRAKE_EN
            ld_v = rev_v | (brake_rel_s & (new_mag_v != '0));
`else
            ld_v = rev_v;
`endif
            if (ld_v) begin
                dead_d[i] = DEAD_L;
            end else if (dead_q[i] != '0) begin
                dead_d[i] = dead_q[i] - CNT_W'(1);
            end else begin
                dead_d[i] = '0;
            end

            mag_v = mag_of(act_q[i]);
            run_v = (dead_q[i] == '0) & (cnt_q < mag_v);
`ifdef PWM_BRAKE_EN
            if (brake) begin
                ch_a_d[i] = 1'b1;
                ch_b_d[i] = 1'b1;
            end else if (brake_hold_q) begin
                ch_a_d[i] = 1'b0;
                ch_b_d[i] = 1'b0;
            end else begin
                ch_a_d[i] = run_v & ~act_q[i][DUTY_W-1];
                ch_b_d[i] = run_v &  act_q[i][DUTY_W-1];
            end
`else
            ch_a_d[i] = run_v & ~act_q[i][DUTY_W-1];
            ch_b_d[i] = run_v &  act_q[i][DUTY_W-1];
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            period_strt_q <= 1'b0;
            pend_vld_q    <= '0;
            dir_q         <= '0;
            ch_a_q        <= '0;
            ch_b_q        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= '0;
                act_q[i]  <= '0;
                dead_q[i] <= '0;
            end
`ifdef PWM_BRAKE_EN
            brake_hold_q  <= 1'b0;
`endif
        end else begin
            cnt_q         <= cnt_d;
            period_strt_q <= period_strt_d;
            pend_vld_q    <= pend_vld_d;
            dir_q         <= dir_d;
            ch_a_q        <= ch_a_d;
            ch_b_q        <= ch_b_d;
            for (int i = 0; i < NUM_CH; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
                dead_q[i] <= dead_d[i];
            end
`ifdef PWM_BRAKE_EN
            brake_hold_q  <= brake_hold_d;
`endif
        end
    end

    assign CH_A        = ch_a_q;
    assign CH_B        = ch_b_q;
    assign period_strt = period_strt_q;

endmodule

// File: tb/tb_pwm_hbridge_mc.sv
// Self-checking bench for pwm_hbridge_mc (DUTY_W=8, NUM_CH=3, DEAD_CYC=4) against a period-level reference model.
module tb_pwm_hbridge_mc;
    localparam int NUM_CH   = 3;
    localparam int DUTY_W   = 8;
    localparam int DEAD_CYC = 4;
    localparam int PERIOD   = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DUTY_W-1:0] duty;
    logic              wrt_duty;
    logic [1:0]        wrt_ch;
    logic [NUM_CH-1:0] ch_a;
    logic [NUM_CH-1:0] ch_b;
    logic              period_strt;
`ifdef PWM_BRAKE_EN
    logic              brake = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: integer duties, and a per-period "reversal happened" flag
    int m_c;
    int m_pend [NUM_CH];
    bit m_pvld [NUM_CH];
    int m_act  [NUM_CH];
    bit m_dir  [NUM_CH];
    bit m_deadper [NUM_CH];
    logic [NUM_CH-1:0] exp_a, exp_b;
    logic              exp_ps;

    pwm_hbridge_mc #(.NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .DEAD_CYC(DEAD_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .duty(duty), .wrt_duty(wrt_duty), .wrt_ch(wrt_ch),
        .CH_A(ch_a), .CH_B(ch_b), .period_strt(period_strt)
`ifdef PWM_BRAKE_EN
        , .brake(brake)
`endif
    );

    always #5 clk = ~clk;

    function automatic int mag_of(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > PERIOD - 1) ? PERIOD - 1 : m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_c = 0;
        exp_a = '0; exp_b = '0; exp_ps = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_pend[i] = 0; m_pvld[i] = 1'b0; m_act[i] = 0; m_dir[i] = 1'b0; m_deadper[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit wr, input int ch, input int d);
        bit run, hit, upd, sgn;
        for (int i = 0; i < NUM_CH; i++) begin
            run = (m_c < mag_of(m_act[i])) && !(m_deadper[i] && m_c < DEAD_CYC);
            exp_a[i] = run && (m_act[i] >= 0);
            exp_b[i] = run && (m_act[i] < 0);
        end
        exp_ps = (m_c == PERIOD - 1);
        for (int i = 0; i < NUM_CH; i++) begin
            hit = wr && (ch < NUM_CH) && (ch == i);
            if (m_c == PERIOD - 1) begin
                upd = hit || m_pvld[i];
                if (hit) begin m_act[i] = d; m_pend[i] = d; end
                else if (m_pvld[i]) m_act[i] = m_pend[i];
                m_pvld[i] = 1'b0;
                sgn = (m_act[i] < 0);
                m_deadper[i] = upd && (mag_of(m_act[i]) != 0) && (sgn != m_dir[i]);
                if (m_deadper[i]) m_dir[i] = sgn;
            end else if (hit) begin
                m_pend[i] = d;
                m_pvld[i] = 1'b1;
            end
        end
        m_c = (m_c + 1) % PERIOD;
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge
    task automatic step(input bit wr, input int ch, input int d);
        wrt_duty = wr;
        wrt_ch   = 2'(ch);
        duty     = 8'(d);
        @(posedge clk);
        model_edge(wr, ch, d);
        @(negedge clk);
        wrt_duty = 1'b0;
        check("cycle", {26'd0, ch_a, ch_b, period_strt}, {26'd0, exp_a, exp_b, exp_ps});
    endtask

    task automatic sync_to(input int target);
        for (int k = 0; k < PERIOD + 2 && m_c != target; k++) step(1'b0, 0, 0);
    endtask

    task automatic count_period(output int a0, output int b0, output int rest, output int ps);
        a0 = 0; b0 = 0; rest = 0; ps = 0;
        for (int k = 0; k < PERIOD; k++) begin
            step(1'b0, 0, 0);
            a0   += int'(ch_a[0]);
            b0   += int'(ch_b[0]);
            rest += int'(ch_a[1]) + int'(ch_b[1]) + int'(ch_a[2]) + int'(ch_b[2]);
            ps   += int'(period_strt);
        end
    endtask

    task automatic expect_period(input string tag, input int ea0, input int eb0);
        int a0, b0, rest, ps;
        sync_to(0);
        count_period(a0, b0, rest, ps);
        check({tag, "_a0"}, 32'(a0), 32'(ea0));
        check({tag, "_b0"}, 32'(b0), 32'(eb0));
    endtask

    initial begin
        int a0, b0, rest, ps, ch, d, gap;
        rst_n = 1'b0; wrt_duty = 1'b0; wrt_ch = 2'd0; duty = 8'd0;
        model_reset();
        #1;
        check("reset_outs", {29'd0, ch_a[0], ch_b[0], period_strt}, 32'd0);
        repeat (3) @(negedge clk);
        check("reset_hold", {26'd0, ch_a, ch_b, period_strt}, 32'd0);
        rst_n = 1'b1;

        // +32 on ch0; other channels must stay idle
        repeat (5) step(1'b0, 0, 0);
        step(1'b1, 0, 32);
        sync_to(0);
        count_period(a0, b0, rest, ps);
        check("fwd32_a0", 32'(a0), 32'd32);
        check("fwd32_b0", 32'(b0), 32'd0);
        check("fwd32_others", 32'(rest), 32'd0);

        // Reversal to -32 costs the first DEAD_CYC cycles once
        step(1'b1, 0, -32);
        expect_period("rev32", 0, 28);
        expect_period("rev32_steady", 0, 32);

        // Most negative word saturates; then reverse to full forward
        step(1'b1, 0, -128);
        expect_period("sat_neg", 0, 127);
        step(1'b1, 0, 127);
        expect_period("rev127", 123, 0);
        expect_period("fwd127", 127, 0);

        // Last write of a period wins; running period untouched
        sync_to(50);
        step(1'b1, 0, 10);
        sync_to(60);
        step(1'b1, 0, 20);
        expect_period("last_wins", 20, 0);

        // Write on the boundary cycle applies to the very next period
        sync_to(PERIOD - 1);
        step(1'b1, 0, 5);
        count_period(a0, b0, rest, ps);
        check("boundary_wr_a0", 32'(a0), 32'd5);

        // Out-of-range channel index is ignored
        step(1'b1, 3, -60);
        sync_to(0);
        count_period(a0, b0, rest, ps);
        check("bad_ch_a0", 32'(a0), 32'd5);
        check("bad_ch_rest", 32'(rest), 32'd0);

        // Randomised writes, some aimed at the boundary cycle
        for (int n = 0; n < 30; n++) begin
            ch  = int'($urandom_range(0, 3));
            d   = int'($urandom_range(0, 255)) - 128;
            gap = int'($urandom_range(0, 150));
            if ($urandom_range(0, 3) == 0) sync_to(PERIOD - 1);
            else repeat (gap) step(1'b0, 0, 0);
            step(1'b1, ch, d);
        end
        sync_to(0);
        sync_to(0);

        // Asynchronous reset in the middle of a pulse
        step(1'b1, 0, 64);
        step(1'b1, 1, -64);
        sync_to(0);
        sync_to(20);
        check("pre_rst_a0", {31'd0, ch_a[0]}, 32'd1);
        check("pre_rst_b1", {31'd0, ch_b[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", {26'd0, ch_a, ch_b, period_strt}, 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_period(a0, b0, rest, ps);
        check("post_rst_ps", 32'(ps), 32'd1);
        check("post_rst_a0", 32'(a0), 32'd0);
        expect_period("post_rst_idle", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
